// File: rtl/sha256_ctrl_pkg.sv
// Shared types and constants for the SHA-256 compression sequencer and its datapath.
package sha256_ctrl_pkg;

  localparam int ROUNDS    = 64;
  localparam int MSG_WORDS = 16;
  localparam int RIDX_W    = 6;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    UPDATE,
    DONE
  } state_e;

  // Initial hash value H(0), used by the datapath on load_iv.
  localparam logic [31:0] SHA256_IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

endpackage

// File: rtl/sha256_round_cnt.sv
// Round index counter: clears, advances on enable and wraps to zero after the terminal count.
module sha256_round_cnt
  import sha256_ctrl_pkg::*;
#(
  parameter int W    = RIDX_W,
  parameter int LAST = ROUNDS - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  localparam logic [W-1:0] LAST_V = W'(LAST);

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == LAST_V);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// Stallable SHA-256 block sequencer: block handshake, IV/chain load, round enables,
// H update and digest handshake. All outputs decode from registered state only.
module sha256_round_ctrl
  import sha256_ctrl_pkg::*;
#(
  parameter int ROUNDS    = sha256_ctrl_pkg::ROUNDS,
  parameter int MSG_WORDS = sha256_ctrl_pkg::MSG_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        blk_valid,
  input  logic        blk_first,
  input  logic        blk_last,
  output logic        blk_ready,
  output logic        load_iv,
  output logic        load_abcd,
  output logic        round_en,
  output logic [5:0]  round_idx,
  output logic [3:0]  msg_rd_idx,
  output logic        w_sel_sched,
  output logic        h_update,
  output logic        digest_valid,
  input  logic        digest_ack,
  output logic        busy,
  output logic [15:0] blk_cnt
);

  localparam logic [RIDX_W-1:0] MSG_LIM = RIDX_W'(MSG_WORDS);

  state_e            state_q, state_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              iv_ok_q, iv_ok_d;
  logic [15:0]       blk_cnt_q, blk_cnt_d;
  logic [RIDX_W-1:0] ridx;
  logic              ridx_tc;

  sha256_round_cnt #(
    .W    (RIDX_W),
    .LAST (ROUNDS - 1)
  ) u_round_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_q == IDLE),
    .en_i  (state_q == ROUND),
    .cnt_o (ridx),
    .tc_o  (ridx_tc)
  );

  assign round_idx   = ridx;
  assign msg_rd_idx  = ridx[3:0];
  assign w_sel_sched = (ridx >= MSG_LIM);
  assign blk_cnt     = blk_cnt_q;

  always_comb begin
    state_d      = state_q;
    first_d      = first_q;
    last_d       = last_q;
    iv_ok_d      = iv_ok_q;
    blk_cnt_d    = blk_cnt_q;
    blk_ready    = 1'b0;
    load_iv      = 1'b0;
    load_abcd    = 1'b0;
    round_en     = 1'b0;
    h_update     = 1'b0;
    digest_valid = 1'b0;
    busy         = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        blk_ready = 1'b1;
        if (blk_valid) begin
          // A block arriving without a valid chain value must start from the IV.
          first_d = blk_first | ~iv_ok_q;
          last_d  = blk_last;
          state_d = LOAD;
        end
      end
      LOAD: begin
        load_abcd = 1'b1;
        load_iv   = first_q;
        if (first_q) begin
          blk_cnt_d = '0;
          iv_ok_d   = 1'b1;
        end
        state_d = ROUND;
      end
      ROUND: begin
        round_en = 1'b1;
        if (ridx_tc) state_d = UPDATE;
      end
      UPDATE: begin
        h_update  = 1'b1;
        blk_cnt_d = blk_cnt_q + 16'd1;
        if (last_q) begin
          iv_ok_d = 1'b0;
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      DONE: begin
        digest_valid = 1'b1;
        if (digest_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      iv_ok_q   <= 1'b0;
      blk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      last_q    <= last_d;
      iv_ok_q   <= iv_ok_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: timeline model of the block schedule plus a behavioural
// SHA-256 datapath driven by the DUT's control pulses, checked against known digests.
module tb_sha256_round_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        blk_valid = 1'b0, blk_first = 1'b0, blk_last = 1'b0, digest_ack = 1'b0;
  logic        blk_ready, load_iv, load_abcd, round_en, w_sel_sched, h_update;
  logic        digest_valid, busy;
  logic [5:0]  round_idx;
  logic [3:0]  msg_rd_idx;
  logic [15:0] blk_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_iv = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (load_iv) n_iv <= n_iv + 1;

  sha256_round_ctrl dut (
    .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid), .blk_first(blk_first),
    .blk_last(blk_last), .blk_ready(blk_ready), .load_iv(load_iv), .load_abcd(load_abcd),
    .round_en(round_en), .round_idx(round_idx), .msg_rd_idx(msg_rd_idx),
    .w_sel_sched(w_sel_sched), .h_update(h_update), .digest_valid(digest_valid),
    .digest_ack(digest_ack), .busy(busy), .blk_cnt(blk_cnt)
  );

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [31:0] blk_abc [16] = '{32'h61626380, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000018};
  logic [31:0] blk_n1 [16] = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                               32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                               32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                               32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  logic [31:0] blk_n2 [16] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                               32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000001c0};
  localparam logic [255:0] DIG_ABC  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_NIST = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  // Behavioural datapath: message buffer captured at the handshake, schedule computed in place.
  logic [31:0] nxt_blk [16];
  logic [31:0] mbuf [16];
  logic [31:0] H [8];
  logic [31:0] A [8];
  logic [31:0] w_cur, t1, t2;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  always_comb begin
    w_cur = mbuf[msg_rd_idx];
    if (w_sel_sched)
      w_cur = (rotr(mbuf[msg_rd_idx - 4'd2], 17) ^ rotr(mbuf[msg_rd_idx - 4'd2], 19) ^ (mbuf[msg_rd_idx - 4'd2] >> 10))
            + mbuf[msg_rd_idx - 4'd7]
            + (rotr(mbuf[msg_rd_idx - 4'd15], 7) ^ rotr(mbuf[msg_rd_idx - 4'd15], 18) ^ (mbuf[msg_rd_idx - 4'd15] >> 3))
            + mbuf[msg_rd_idx];
    t1 = A[7] + (rotr(A[4], 6) ^ rotr(A[4], 11) ^ rotr(A[4], 25))
       + ((A[4] & A[5]) ^ (~A[4] & A[6])) + K[round_idx] + w_cur;
    t2 = (rotr(A[0], 2) ^ rotr(A[0], 13) ^ rotr(A[0], 22))
       + ((A[0] & A[1]) ^ (A[0] & A[2]) ^ (A[1] & A[2]));
  end

  always @(posedge clk) begin
    if (blk_valid && blk_ready) mbuf <= nxt_blk;
    if (load_iv) begin
      H <= sha256_ctrl_pkg::SHA256_IV;
      A <= sha256_ctrl_pkg::SHA256_IV;
    end else if (load_abcd) begin
      A <= H;
    end
    if (round_en) begin
      if (w_sel_sched) mbuf[msg_rd_idx] <= w_cur;
      A <= '{t1 + t2, A[0], A[1], A[2], A[3] + t1, A[4], A[5], A[6]};
    end
    if (h_update) for (int i = 0; i < 8; i++) H[i] <= H[i] + A[i];
  end

  // Timeline model: m_ph counts cycles since acceptance (0 = idle), m_done = digest pending.
  int m_ph = 0;
  int m_cnt = 0;
  bit m_done = 1'b0, m_first = 1'b0, m_last = 1'b0, m_iv = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ph <= 0; m_cnt <= 0; m_done <= 1'b0; m_first <= 1'b0; m_last <= 1'b0; m_iv <= 1'b0;
    end else if (m_done) begin
      if (digest_ack) m_done <= 1'b0;
    end else if (m_ph == 0) begin
      if (blk_valid) begin
        m_ph <= 1; m_first <= blk_first || !m_iv; m_last <= blk_last;
      end
    end else begin
      if (m_ph == 1 && m_first) begin
        m_cnt <= 0; m_iv <= 1'b1;
      end
      if (m_ph == 66) begin
        m_ph <= 0; m_cnt <= (m_cnt + 1) % 65536;
        if (m_last) begin
          m_done <= 1'b1; m_iv <= 1'b0;
        end
      end else begin
        m_ph <= m_ph + 1;
      end
    end
  end

  function automatic logic [33:0] expv(input int ph, input bit dn, input bit f, input int cnt);
    bit ren = (ph >= 2) && (ph <= 65);
    int r = ren ? ph - 2 : 0;
    logic [5:0] r6 = 6'(r);
    return {ph == 0 && !dn, ph == 1 && f, ph == 1, ren, r6, r6[3:0], r >= 16,
            ph == 66, dn, ph != 0 || dn, 16'(cnt)};
  endfunction

  function automatic logic [33:0] act_vec();
    return {blk_ready, load_iv, load_abcd, round_en, round_idx, msg_rd_idx, w_sel_sched,
            h_update, digest_valid, busy, blk_cnt};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (blk_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("ready_timeout", 256'(blk_ready), 256'(1));
  endtask

  task automatic send_block(input bit f, input bit l, input logic [31:0] w [16],
                            input bit hold, output int t);
    bit ok;
    wait_ready(ok);
    nxt_blk   = w;
    blk_first = f;
    blk_last  = l;
    blk_valid = 1'b1;
    t = cyc;
    @(negedge clk);
    if (!hold) blk_valid = 1'b0;
  endtask

  task automatic wait_dv(output int t);
    t = -1;
    for (int i = 0; i < 300; i++) begin
      if (digest_valid) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    if (t < 0) chk("dv_timeout", 256'(digest_valid), 256'(1));
  endtask

  initial begin
    int t, td, t2, t3, n0;
    bit ok;
    for (int i = 0; i < 16; i++) nxt_blk[i] = 32'h0;

    fork
      forever begin
        @(negedge clk);
        if (!rst_n) chk("reset_outputs", 256'(act_vec()), 256'(34'h200000000));
        else chk("model_outputs", 256'(act_vec()), 256'(expv(m_ph, m_done, m_first, m_cnt)));
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_ready", 256'(blk_ready), 256'(1));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_cnt", 256'(blk_cnt), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Single "abc" block, ack tied high.
    digest_ack = 1'b1;
    send_block(1'b1, 1'b1, blk_abc, 1'b0, t);
    chk("abc_load", 256'({load_iv, load_abcd}), 256'(2'b11));
    repeat (16) @(negedge clk);
    chk("abc_round15", 256'({round_idx, msg_rd_idx, w_sel_sched}), 256'({6'd15, 4'd15, 1'b0}));
    @(negedge clk);
    chk("abc_round16", 256'({round_idx, msg_rd_idx, w_sel_sched}), 256'({6'd16, 4'd0, 1'b1}));
    wait_dv(td);
    chk("abc_dv_latency", 256'(td - t), 256'(67));
    chk("abc_digest", {H[0], H[1], H[2], H[3], H[4], H[5], H[6], H[7]}, DIG_ABC);
    @(negedge clk);
    chk("abc_dv_pulse", 256'({digest_valid, blk_ready}), 256'(2'b01));

    // Two-block NIST vector, first block sent without blk_first; ack withheld 10 cycles.
    digest_ack = 1'b0;
    send_block(1'b0, 1'b0, blk_n1, 1'b0, t);
    chk("nist_forced_iv", 256'(load_iv), 256'(1));
    send_block(1'b0, 1'b1, blk_n2, 1'b0, t);
    chk("nist_chain_load", 256'({load_iv, load_abcd}), 256'(2'b01));
    wait_dv(td);
    chk("nist_blk_cnt", 256'(blk_cnt), 256'(2));
    chk("nist_digest", {H[0], H[1], H[2], H[3], H[4], H[5], H[6], H[7]}, DIG_NIST);
    blk_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("nist_hold", 256'({digest_valid, blk_ready}), 256'(2'b10));
    end
    blk_valid  = 1'b0;
    digest_ack = 1'b1;
    @(negedge clk);
    chk("nist_idle_after_ack", 256'({busy, blk_ready, digest_valid}), 256'(3'b010));
    digest_ack = 1'b0;

    // Three-block message with blk_valid held high.
    n0 = n_iv;
    send_block(1'b1, 1'b0, blk_n1, 1'b1, t);
    blk_first = 1'b0;
    wait_ready(ok);
    t2 = cyc;
    chk("three_gap1", 256'(t2 - t), 256'(67));
    @(negedge clk);
    blk_last = 1'b1;
    wait_ready(ok);
    t3 = cyc;
    chk("three_gap2", 256'(t3 - t2), 256'(67));
    @(negedge clk);
    blk_valid = 1'b0;
    wait_dv(td);
    chk("three_dv_latency", 256'(td - t3), 256'(67));
    chk("three_blk_cnt", 256'(blk_cnt), 256'(3));
    chk("three_iv_pulses", 256'(n_iv - n0), 256'(1));
    digest_ack = 1'b1;
    @(negedge clk);

    // Asynchronous reset mid-round, then a block sent without blk_first.
    send_block(1'b1, 1'b1, blk_n1, 1'b0, t);
    for (int i = 0; i < 100 && round_idx != 6'd30; i++) @(negedge clk);
    chk("rst_reach_r30", 256'(round_idx), 256'(30));
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 256'(act_vec()), 256'(34'h200000000));
    @(negedge clk);
    rst_n = 1'b1;
    send_block(1'b0, 1'b1, blk_abc, 1'b0, t);
    chk("post_rst_iv", 256'(load_iv), 256'(1));
    wait_dv(td);
    chk("post_rst_digest", {H[0], H[1], H[2], H[3], H[4], H[5], H[6], H[7]}, DIG_ABC);
    chk("post_rst_cnt", 256'(blk_cnt), 256'(1));

    // Randomized handshake traffic checked by the timeline model every cycle.
    repeat (2500) begin
      @(negedge clk);
      blk_valid  = 1'($urandom_range(0, 1));
      blk_first  = 1'($urandom_range(0, 1));
      blk_last   = ($urandom_range(0, 2) == 0);
      digest_ack = 1'($urandom_range(0, 1));
    end
    blk_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_round_ctrl.md
# sha256_round_ctrl

Sequencer for the SHA-256 compression datapath: the H1–H8 hash registers, the a–h working registers, the iteration (T1/T2) stage and the 16-word message buffer. It accepts one 512-bit block at a time through a valid/ready handshake and generates the control pulses the datapath consumes:

- IV or chain load,
- the a–h load,
- 64 round enables with round index and message-word select,
- the final H += a..h update.

It replaces the free-running select counter with an explicit, stallable FSM that supports multi-block messages and a digest handshake.

## Interface

Parameters:
- ROUNDS, 64, compression rounds per block
- MSG_WORDS, 16, message words per block read directly from buffer

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- blk_valid  in  1  a block is present in the message buffer
- blk_first  in  1  block is first of a message (sampled with handshake)
- blk_last  in  1  block is last of a message (sampled with handshake)
- blk_ready  out  1  controller accepts a block this cycle
- load_iv  out  1  load H1–H8 and a–h from the SHA-256 IV constants
- load_abcd  out  1  load a–h from H1–H8 (ignored by datapath when load_iv=1)
- round_en  out  1  advance working registers one round
- round_idx  out  6  round number; selects K constant
- msg_rd_idx  out  4  message buffer word address (= round_idx[3:0])
- w_sel_sched  out  1  0: W from message buffer, 1: W from schedule
- h_update  out  1  H_i <= H_i + working register
- digest_valid  out  1  H1–H8 hold final digest
- digest_ack  in  1  consumer has taken digest
- busy  out  1  block in progress (not IDLE)
- blk_cnt  out  16  blocks completed in current message, wraps at 2^16

## Operation

- FSM states: IDLE, LOAD, ROUND, UPDATE, DONE.
- **IDLE**
  - blk_ready=1.
  - On blk_valid: latch first_q = blk_first OR !iv_ok, and latch last_q; go to LOAD.
- **LOAD** (1 cycle)
  - load_abcd=1 and load_iv=first_q.
  - If first_q: blk_cnt<=0 and iv_ok<=1.
- **ROUND** (ROUNDS cycles)
  - round_en=1; round_idx runs 0..63.
  - w_sel_sched = (round_idx >= MSG_WORDS).
  - msg_rd_idx=round_idx[3:0].
  - Buffer reads are combinational, zero latency.
  - After round_idx=63: go to UPDATE, with round_idx reset to 0.
- **UPDATE** (1 cycle)
  - h_update=1; blk_cnt increments, wrapping at 2^16.
  - If last_q: go to DONE and set iv_ok<=0. Otherwise return to IDLE.
- **DONE**
  - digest_valid=1, held until digest_ack=1 is sampled; then go to IDLE.
- Forced IV: iv_ok clears on reset and after each last block. A block accepted with blk_first=0 while iv_ok=0 is treated as first.
- All outputs are decoded from state and counter registers only, with no input-to-output combinational paths.
- Inputs outside IDLE (blk_valid) or outside DONE (digest_ack) are ignored.

## Timing

- Handshake cycle T (blk_valid & blk_ready):
  - LOAD at T+1;
  - ROUND at T+2..T+65;
  - UPDATE at T+66;
  - then either digest_valid from T+67 (last block) or blk_ready=1 at T+67 (otherwise).
- Throughput: 67 cycles per block with back-to-back blk_valid.
- digest_ack high in the first DONE cycle gives IDLE at the next edge; digest_valid is high for exactly one cycle.
- Reset, asserted at any time including mid-round:
  - state=IDLE, round_idx=0, blk_cnt=0, iv_ok=0;
  - all pulses and digest_valid=0, busy=0;
  - blk_ready=1 (IDLE decode).
  - Datapath register contents are don't-care after reset; the next block always loads the IV.

## Structure

- Package sha256_ctrl_pkg holds:
  - the state enum (IDLE, LOAD, ROUND, UPDATE, DONE);
  - ROUNDS, MSG_WORDS, and the round-index width localparam;
  - the SHA-256 IV constants shared with the datapath.
- One sub-module, sha256_round_cnt:
  - 6-bit counter with clear and enable;
  - terminal-count flag at ROUNDS-1.
- The FSM and blk_cnt live in the top.

## Test plan

- Single block, blk_first=1, blk_last=1, digest_ack tied high:
  - load_iv and load_abcd high at T+1;
  - round_en for 64 cycles, round_idx 0..63;
  - msg_rd_idx wraps 15→0 at round 16, when w_sel_sched goes 1;
  - h_update at T+66; one-cycle digest_valid at T+67.
- Three-block message (first, -, last), blk_valid held high:
  - blk_ready pulses at T, T+67, T+134;
  - load_iv only on block 1;
  - blk_cnt=3 at digest_valid; digest_valid only after block 3.
- Hold digest_ack low 10 cycles in DONE:
  - digest_valid stays high;
  - blk_ready stays 0 while blk_valid is asserted;
  - IDLE is reached one cycle after ack.
- First block after reset sent with blk_first=0: load_iv=1 forced. Same for a block following a completed last block.
- rst_n pulsed low at round_idx=30: all outputs reach reset values asynchronously; the next block completes normally with load_iv=1.
- Compare against known digests:
  - "abc" → ba7816bf…;
  - a 2-block NIST vector → 248d6a61… in H1–H8 at digest_valid.
